// File: rtl/fetch_arbiter_pkg.sv
// Shared IF/ID pipeline constants and types for the instruction-memory fetch arbiter.
// The optional starvation guard is enabled by defining FETCH_ARB_STARVE_EN.
package fetch_arbiter_pkg;

  localparam int XLEN         = 32;
  localparam int INSTR_W      = 32;
  localparam int FSM_STATE_W  = 2;
  localparam int STARVE_CNT_W = 4;

  // Value presented on the fetched-word bus when no fetch completes
  localparam logic [INSTR_W-1:0] IF_BUBBLE = '0;

  typedef enum logic [FSM_STATE_W-1:0] {
    IDLE   = 2'd0,
    F_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;

  // Clamp the starvation limit into the range the 4-bit counter can represent
  function automatic logic [STARVE_CNT_W-1:0] starve_limit_cnt(input int limit);
    logic [STARVE_CNT_W-1:0] result;
    if (limit < 1)
      result = 4'd1;
    else if (limit > 15)
      result = 4'd15;
    else
      result = limit[STARVE_CNT_W-1:0];
    return result;
  endfunction

endpackage

// File: rtl/fetch_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the instruction memory.
// The arbiter connects through the slave modport; the environment drives the master modport.
interface fetch_arbiter_if;
  import fetch_arbiter_pkg::*;

  logic               f_req;
  logic [XLEN-1:0]    f_addr;
  logic               f_redirect;

  logic               d_req;
  logic               d_we;
  logic [XLEN-1:0]    d_addr;
  logic [XLEN-1:0]    d_wdata;
  logic               d_ack;
  logic [XLEN-1:0]    d_rdata;

  logic               mem_req;
  logic               mem_we;
  logic [XLEN-1:0]    mem_addr;
  logic [XLEN-1:0]    mem_wdata;
  logic               mem_ack;
  logic [XLEN-1:0]    mem_rdata;

  logic               FREEZE;
  logic [INSTR_W-1:0] Instr1_fIM;

  modport slave (
    input  f_req, f_addr, f_redirect,
    input  d_req, d_we, d_addr, d_wdata,
    output d_ack, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output FREEZE, Instr1_fIM
  );

  modport master (
    output f_req, f_addr, f_redirect,
    output d_req, d_we, d_addr, d_wdata,
    input  d_ack, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  FREEZE, Instr1_fIM
  );

endinterface

// File: rtl/fetch_arb_starve.sv
// Starvation counter for the data requester: counts arbitration rounds that data loses
// to fetch, saturating at the limit. Only built when FETCH_ARB_STARVE_EN is defined.
module fetch_arb_starve
  import fetch_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic lost,
  input  logic d_grant,
  output logic starved
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = starve_limit_cnt(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] count;

  // Count lost rounds up to the limit; a data grant or reset starts over from zero
  always_ff @(posedge CLK) begin
    if (!RESET)
      count <= '0;
    else if (d_grant)
      count <= '0;
    else if (lost && (count < LIMIT))
      count <= count + 4'd1;
  end

  assign starved = (count == LIMIT);

endmodule

// File: rtl/fetch_arbiter.sv
// Arbiter sharing one instruction-memory port between the fetch stage and a data/debug
// requester, with at most one memory transaction outstanding. Fetch normally has priority;
// defining FETCH_ARB_STARVE_EN adds a starvation guard that lets data win after
// STARVE_LIMIT lost rounds.
module fetch_arbiter
  import fetch_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  fetch_arbiter_if.slave  bus
);

  arb_state_t      state;
  logic            kill;
  logic            mem_req_q;
  logic            mem_we_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [XLEN-1:0] mem_wdata_q;
  logic            d_ack_q;
  logic [XLEN-1:0] d_rdata_q;

  logic            starved;
  logic            fetch_grant;
  logic            data_grant;
  logic            fetch_done;

  // Data only overrides fetch priority when it is starved and actually asking
  assign fetch_grant = (state == IDLE) && bus.f_req && !(starved && bus.d_req);
  assign data_grant  = (state == IDLE) && bus.d_req && !fetch_grant;

`ifdef FETCH_ARB_STARVE_EN
  logic d_lost;

  assign d_lost = (state == IDLE) && bus.d_req && !data_grant;

  fetch_arb_starve #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .CLK     (CLK),
    .RESET   (RESET),
    .lost    (d_lost),
    .d_grant (data_grant),
    .starved (starved)
  );
`else
  // The clamped limit is never zero, so this is constant 0: strict fetch priority
  assign starved = (starve_limit_cnt(STARVE_LIMIT) == 4'd0);
`endif

  // A fetch completes only on an unkilled ack; a redirect in the ack cycle itself also kills it
  assign fetch_done = RESET && (state == F_BUSY) && bus.mem_ack && !kill && !bus.f_redirect;

  // Main arbitration FSM with registered memory request and data-side outputs
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state       <= IDLE;
      kill        <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      d_ack_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      d_ack_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fetch_grant) begin
            state       <= F_BUSY;
            kill        <= 1'b0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.f_addr;
            mem_wdata_q <= '0;
          end else if (data_grant) begin
            state       <= D_BUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.d_we;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
          end
        end
        F_BUSY: begin
          if (bus.mem_ack) begin
            state     <= IDLE;
            kill      <= 1'b0;
            mem_req_q <= 1'b0;
          end else if (bus.f_redirect) begin
            kill <= 1'b1;
          end
        end
        D_BUSY: begin
          if (bus.mem_ack) begin
            state     <= IDLE;
            mem_req_q <= 1'b0;
            d_ack_q   <= 1'b1;
            if (!mem_we_q)
              d_rdata_q <= bus.mem_rdata;
          end
        end
        default: begin
          state     <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.d_ack      = d_ack_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.FREEZE     = bus.f_req && !fetch_done;
  assign bus.Instr1_fIM = fetch_done ? bus.mem_rdata : IF_BUBBLE;

endmodule

// File: tb/tb_fetch_arbiter.sv
// Directed testbench for fetch_arbiter with a transaction-level reference model.
// Builds and checks both with and without FETCH_ARB_STARVE_EN.
module tb_fetch_arbiter;
  import fetch_arbiter_pkg::*;

  localparam int LIMIT = 4;
`ifdef FETCH_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  typedef struct {
    logic        rst_n;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_redirect;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
  } stim_t;

  logic  CLK;
  logic  RESET;
  stim_t cur;
  int    compared;
  int    mismatched;
  bit    chk_en;

  fetch_arbiter_if bus();

  fetch_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: one outstanding transaction record plus a lost-round count
  bit          m_busy;
  bit          m_fetch;
  bit          m_stale;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  bit          m_d_ack;
  logic [31:0] m_d_rdata;
  int          m_lost;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one rising edge, then drive the next input vector
  task automatic applyStimulus();
    @(posedge CLK);
    #1;
    RESET          = cur.rst_n;
    bus.f_req      = cur.f_req;
    bus.f_addr     = cur.f_addr;
    bus.f_redirect = cur.f_redirect;
    bus.d_req      = cur.d_req;
    bus.d_we       = cur.d_we;
    bus.d_addr     = cur.d_addr;
    bus.d_wdata    = cur.d_wdata;
    bus.mem_ack    = cur.mem_ack;
    bus.mem_rdata  = cur.mem_rdata;
  endtask

  // Model update from the inputs seen at each rising edge
  always @(posedge CLK) begin
    bit starved;
    bit fetch_wins;
    m_d_ack = 1'b0;
    if (RESET !== 1'b1) begin
      m_busy    = 1'b0;
      m_stale   = 1'b0;
      m_d_rdata = '0;
      m_lost    = 0;
    end else if (m_busy) begin
      if (m_fetch && bus.f_redirect) m_stale = 1'b1;
      if (bus.mem_ack) begin
        m_busy = 1'b0;
        if (!m_fetch) begin
          m_d_ack = 1'b1;
          if (!m_we) m_d_rdata = bus.mem_rdata;
        end
      end
    end else begin
      starved    = STARVE_EN && (m_lost >= LIMIT) && bus.d_req;
      fetch_wins = bus.f_req && !starved;
      if (fetch_wins) begin
        m_busy = 1'b1; m_fetch = 1'b1; m_stale = 1'b0; m_we = 1'b0; m_addr = bus.f_addr;
        if (bus.d_req && m_lost < LIMIT) m_lost++;
      end else if (bus.d_req) begin
        m_busy = 1'b1; m_fetch = 1'b0; m_we = bus.d_we; m_addr = bus.d_addr; m_wdata = bus.d_wdata;
        m_lost = 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the rising edge
  always @(negedge CLK) begin
    bit completing;
    if (chk_en) begin
      completing = (RESET === 1'b1) && m_busy && m_fetch && bus.mem_ack && !m_stale && !bus.f_redirect;
      checkOutput("cmp_mem_req", 32'(bus.mem_req), 32'(m_busy));
      checkOutput("cmp_d_ack", 32'(bus.d_ack), 32'(m_d_ack));
      checkOutput("cmp_d_rdata", bus.d_rdata, m_d_rdata);
      checkOutput("cmp_freeze", 32'(bus.FREEZE), 32'(bus.f_req && !completing));
      checkOutput("cmp_instr", bus.Instr1_fIM, completing ? bus.mem_rdata : 32'h0);
      if (m_busy) begin
        checkOutput("cmp_mem_addr", bus.mem_addr, m_addr);
        checkOutput("cmp_mem_we", 32'(bus.mem_we), 32'(m_we));
        if (!m_fetch) checkOutput("cmp_mem_wdata", bus.mem_wdata, m_wdata);
      end
    end
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    chk_en     = 1'b0;
    cur        = '{rst_n: 1'b0, f_req: 1'b0, f_addr: 32'h0, f_redirect: 1'b0, d_req: 1'b0,
                   d_we: 1'b0, d_addr: 32'h0, d_wdata: 32'h0, mem_ack: 1'b0, mem_rdata: 32'h0};
    RESET = 1'b0;
    bus.f_req = 1'b0; bus.f_addr = '0; bus.f_redirect = 1'b0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;

    // Reset state, FREEZE follows f_req while in reset
    applyStimulus();
    chk_en = 1'b1;
    cur.f_req = 1'b1;
    applyStimulus();
    #2;
    checkOutput("reset_freeze", 32'(bus.FREEZE), 32'h1);
    checkOutput("reset_mem_req", 32'(bus.mem_req), 32'h0);
    checkOutput("reset_d_ack", 32'(bus.d_ack), 32'h0);
    checkOutput("reset_d_rdata", bus.d_rdata, 32'h0);
    checkOutput("reset_instr", bus.Instr1_fIM, 32'h0);

    // Basic fetch with minimum latency
    cur.rst_n = 1'b1; cur.f_addr = 32'h100;
    applyStimulus();
    #2 checkOutput("a_freeze_grant_cycle", 32'(bus.FREEZE), 32'h1);
    cur.mem_ack = 1'b1; cur.mem_rdata = 32'hCAFE0001;
    applyStimulus();
    #2;
    checkOutput("a_mem_req", 32'(bus.mem_req), 32'h1);
    checkOutput("a_mem_addr", bus.mem_addr, 32'h100);
    checkOutput("a_mem_we", 32'(bus.mem_we), 32'h0);
    checkOutput("a_freeze_ack", 32'(bus.FREEZE), 32'h0);
    checkOutput("a_instr", bus.Instr1_fIM, 32'hCAFE0001);
    cur.mem_ack = 1'b0; cur.f_req = 1'b0;
    applyStimulus();
    #2;
    checkOutput("a_mem_req_done", 32'(bus.mem_req), 32'h0);
    checkOutput("a_instr_done", bus.Instr1_fIM, 32'h0);

    // Simultaneous fetch and data: fetch first, data once fetch drops
    cur.f_req = 1'b1; cur.f_addr = 32'h104; cur.d_req = 1'b1; cur.d_addr = 32'h200;
    applyStimulus();
    cur.mem_ack = 1'b1; cur.mem_rdata = 32'h00001111;
    applyStimulus();
    #2;
    checkOutput("b_fetch_first", bus.mem_addr, 32'h104);
    checkOutput("b_no_d_ack", 32'(bus.d_ack), 32'h0);
    cur.mem_ack = 1'b0; cur.f_req = 1'b0;
    applyStimulus();
    cur.mem_ack = 1'b1; cur.mem_rdata = 32'h12345678;
    applyStimulus();
    #2;
    checkOutput("b_data_addr", bus.mem_addr, 32'h200);
    checkOutput("b_data_we", 32'(bus.mem_we), 32'h0);
    cur.mem_ack = 1'b0; cur.d_req = 1'b0;
    applyStimulus();
    #2;
    checkOutput("b_d_ack", 32'(bus.d_ack), 32'h1);
    checkOutput("b_d_rdata", bus.d_rdata, 32'h12345678);
    applyStimulus();
    #2;
    checkOutput("b_d_ack_pulse", 32'(bus.d_ack), 32'h0);
    checkOutput("b_d_rdata_hold", bus.d_rdata, 32'h12345678);

    // Redirect during a 3-cycle fetch kills it and re-fetches the new address
    cur.f_req = 1'b1; cur.f_addr = 32'h100;
    applyStimulus();
    applyStimulus();
    cur.f_redirect = 1'b1; cur.f_addr = 32'h400;
    applyStimulus();
    cur.f_redirect = 1'b0; cur.mem_ack = 1'b1; cur.mem_rdata = 32'hBAD0BAD0;
    applyStimulus();
    #2;
    checkOutput("c_killed_freeze", 32'(bus.FREEZE), 32'h1);
    checkOutput("c_killed_instr", bus.Instr1_fIM, 32'h0);
    cur.mem_ack = 1'b0;
    applyStimulus();
    cur.mem_ack = 1'b1; cur.mem_rdata = 32'h04000013;
    applyStimulus();
    #2;
    checkOutput("c_refetch_addr", bus.mem_addr, 32'h400);
    checkOutput("c_refetch_instr", bus.Instr1_fIM, 32'h04000013);
    cur.mem_ack = 1'b0; cur.f_req = 1'b0;
    applyStimulus();

    // Data write: write data reaches memory, read data unchanged
    cur.d_req = 1'b1; cur.d_we = 1'b1; cur.d_addr = 32'h300; cur.d_wdata = 32'hDEADBEEF;
    applyStimulus();
    cur.d_req = 1'b0;
    applyStimulus();
    #2;
    checkOutput("d_mem_we", 32'(bus.mem_we), 32'h1);
    checkOutput("d_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    checkOutput("d_mem_addr", bus.mem_addr, 32'h300);
    cur.mem_ack = 1'b1; cur.mem_rdata = 32'h00000055;
    applyStimulus();
    cur.mem_ack = 1'b0; cur.d_we = 1'b0;
    applyStimulus();
    #2;
    checkOutput("d_write_ack", 32'(bus.d_ack), 32'h1);
    checkOutput("d_write_rdata", bus.d_rdata, 32'h12345678);
    applyStimulus();
    #2 checkOutput("d_write_ack_pulse", 32'(bus.d_ack), 32'h0);

    // Reset in the middle of a fetch; the late ack is a stray in IDLE
    cur.f_req = 1'b1; cur.f_addr = 32'h500;
    applyStimulus();
    applyStimulus();
    cur.rst_n = 1'b0;
    applyStimulus();
    #2;
    checkOutput("e_reset_freeze", 32'(bus.FREEZE), 32'h1);
    cur.rst_n = 1'b1; cur.mem_ack = 1'b1; cur.mem_rdata = 32'h00000077; cur.f_req = 1'b0;
    applyStimulus();
    #2;
    checkOutput("e_mem_req_cleared", 32'(bus.mem_req), 32'h0);
    checkOutput("e_stray_instr", bus.Instr1_fIM, 32'h0);
    cur.mem_ack = 1'b0;
    applyStimulus();
    #2;
    checkOutput("e_stray_mem_req", 32'(bus.mem_req), 32'h0);
    checkOutput("e_stray_d_ack", 32'(bus.d_ack), 32'h0);

`ifdef FETCH_ARB_STARVE_EN
    // Held fetch and data: data wins the fifth arbitration round
    cur.f_req = 1'b1; cur.f_addr = 32'h600; cur.d_req = 1'b1; cur.d_addr = 32'h200; cur.d_we = 1'b0;
    applyStimulus();
    for (int i = 0; i < LIMIT; i++) begin
      cur.mem_ack = 1'b1; cur.mem_rdata = 32'(i);
      applyStimulus();
      #2 checkOutput("f_fetch_round", bus.mem_addr, 32'h600);
      cur.mem_ack = 1'b0;
      applyStimulus();
    end
    cur.mem_ack = 1'b1; cur.mem_rdata = 32'h0000ABCD;
    applyStimulus();
    #2 checkOutput("f_starved_data_addr", bus.mem_addr, 32'h200);
    cur.mem_ack = 1'b0; cur.d_req = 1'b0; cur.f_req = 1'b0;
    applyStimulus();
    #2 checkOutput("f_starved_d_rdata", bus.d_rdata, 32'h0000ABCD);
    applyStimulus();
`endif

    applyStimulus();
    applyStimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_arbiter.md
FETCH_ARBITER -- requirements
Module: fetch_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: data-side wait cycles before data pre-empts fetch priority (range 1..15).
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RESET  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port f_req  input  1  fetch requester wants an instruction word.
REQ-005 SHALL have port f_addr  input  32  fetch byte address, word-aligned.
REQ-006 SHALL have port f_redirect  input  1  taken branch; the outstanding fetch is stale.
REQ-007 SHALL have ports d_req input 1, d_we input 1, d_addr input 32, d_wdata input 32  data/debug requester.
REQ-008 SHALL have ports d_ack output 1, d_rdata output 32  data completion pulse and read data.
REQ-009 SHALL have ports mem_req output 1, mem_we output 1, mem_addr output 32, mem_wdata output 32  single-port instruction memory request.
REQ-010 SHALL have ports mem_ack input 1, mem_rdata input 32  memory completion, any latency >= 1 cycle.
REQ-011 SHALL have ports FREEZE output 1, Instr1_fIM output 32  IF stall and fetched word.

Function
REQ-012 SHALL implement FSM states IDLE, F_BUSY, D_BUSY; one memory transaction outstanding at most.
REQ-013 IDLE: SHALL grant fetch if f_req and not starved; else grant data if d_req; else stay IDLE.
REQ-014 On grant SHALL register address, we and wdata into mem_* and assert mem_req from the next cycle until the mem_ack cycle inclusive.
REQ-015 mem_we SHALL be 0 for every fetch transaction.
REQ-016 F_BUSY with mem_ack and no kill: SHALL drive Instr1_fIM = mem_rdata combinationally, deassert FREEZE that cycle, return to IDLE.
REQ-017 FREEZE SHALL be 1 whenever f_req=1, except in the fetch-completion cycle of REQ-016.
REQ-018 Minimum fetch latency SHALL be 2 cycles: grant edge, then the ack cycle.
REQ-019 f_redirect=1 in F_BUSY before or in the ack cycle SHALL set a kill flag; the killed response SHALL be discarded, FREEZE held 1, FSM to IDLE, and f_addr re-arbitrated.
REQ-020 f_redirect in IDLE or D_BUSY SHALL have no effect.
REQ-021 D_BUSY with mem_ack: SHALL pulse d_ack for one cycle with d_rdata = mem_rdata (reads) or unchanged (writes), then return to IDLE.
REQ-022 mem_ack in IDLE SHALL be ignored.
REQ-023 f_req and d_req both in IDLE, not starved: fetch SHALL win.
REQ-024 Instr1_fIM SHALL be 0 outside completion cycles; d_rdata SHALL hold its last value.

Reset
REQ-025 RESET=0 at an edge SHALL force IDLE, clear kill flag and starvation counter, and zero mem_req, mem_we, mem_addr, mem_wdata, d_ack, d_rdata.
REQ-026 Reset mid-transaction SHALL abandon it; a subsequent stray mem_ack SHALL follow REQ-022.
REQ-027 FREEZE SHALL follow REQ-017 during reset, with state IDLE.

Configuration
REQ-028 With FETCH_ARB_STARVE_EN defined: a 4-bit counter SHALL increment per cycle with d_req=1 and no data grant, saturate at STARVE_LIMIT, and clear on data grant; "starved" = counter == STARVE_LIMIT, data then beats fetch in IDLE.
REQ-029 Without FETCH_ARB_STARVE_EN: no counter; starved is constant 0 (strict fetch priority).

Structure
REQ-030 State encoding enum and FSM state width SHALL live in the shared pipeline package with the other IF/ID constants.
REQ-031 Starvation counter SHALL be sub-module fetch_arb_starve, instantiated only under FETCH_ARB_STARVE_EN.

Verification
REQ-032 f_req=1, f_addr=0x100, mem_ack 1 cycle after mem_req -> mem_addr=0x100, mem_we=0, FREEZE low only in ack cycle, Instr1_fIM=mem_rdata.
REQ-033 Same-cycle f_req and d_req (d_addr=0x200) in IDLE, macro off -> fetch granted first; d_ack only once f_req drops.
REQ-034 Macro on, STARVE_LIMIT=4, f_req held, d_req held -> data granted on 5th IDLE decision, mem_addr=0x200, counter cleared.
REQ-035 Fetch to 0x100 with 3-cycle memory latency, f_redirect in cycle 2, f_addr=0x400 -> 0x100 data discarded, FREEZE stays 1, next mem_addr=0x400.
REQ-036 d_we=1, d_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF, single-cycle d_ack on mem_ack.
REQ-037 RESET=0 while F_BUSY, mem_ack one cycle later -> IDLE, mem_req=0, ack ignored, no Instr1_fIM update.
